// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Brief    : Golden sequencer codes and monitor state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam logic [2:0] SEQ_S0 = 3'b000;
  localparam logic [2:0] SEQ_S1 = 3'b101;
  localparam logic [2:0] SEQ_S2 = 3'b001;
  localparam logic [2:0] SEQ_S3 = 3'b011;
  localparam logic [2:0] SEQ_S4 = 3'b110;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Synchronous-reset up-counter that sticks at all-ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/seq_monitor.sv
// ============================================================================
// Module   : seq_monitor
// Brief    : Locks onto the golden 3-bit sequencer cycle and flags deviations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_monitor
  import seq_pkg::*;
#(
  parameter int HOLD_LEN  = 3,
  parameter int ERR_CNT_W = 8,
  parameter int PER_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           number,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [PER_CNT_W-1:0] period_cnt
);

  localparam int HOLD_W = $clog2(HOLD_LEN + 1);
  localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(HOLD_LEN);

  mon_state_t        r_state, w_state_nxt;
  logic [2:0]        r_exp, w_exp_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
  logic              w_err, w_per_inc;
  logic              r_err_pulse, r_err_sticky;

  assign w_hold_inc = r_hold + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_exp   <= SEQ_S0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_hold_nxt  = r_hold;
    w_err       = 1'b0;
    w_per_inc   = 1'b0;
    if (en) begin
      case (r_state)
        HUNT: begin
          if (number == SEQ_S0) begin
            w_state_nxt = TRACK;
            w_exp_nxt   = SEQ_S1;
            w_hold_nxt  = '0;
          end
        end
        TRACK: begin
          // A mismatching sample is never reused for acquisition, even a 000.
          if (number != r_exp) begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
            w_hold_nxt  = '0;
          end else begin
            case (number)
              SEQ_S0: begin
                w_exp_nxt = SEQ_S1;
                w_per_inc = 1'b1;
              end
              SEQ_S1: w_exp_nxt = SEQ_S2;
              SEQ_S2: begin
                w_exp_nxt  = SEQ_S3;
                w_hold_nxt = '0;
              end
              SEQ_S3: begin
                w_hold_nxt = w_hold_inc;
                w_exp_nxt  = (w_hold_inc < c_HOLD_MAX) ? SEQ_S3 : SEQ_S4;
              end
              SEQ_S4: w_exp_nxt = SEQ_S0;
              default: ;
            endcase
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) begin
        r_err_sticky <= 1'b1;
      end else if (en && err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_err),
    .q   (err_cnt)
  );

  sat_counter #(.W(PER_CNT_W)) u_per_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_per_inc),
    .q   (period_cnt)
  );

  assign locked     = (r_state == TRACK);
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_seq_monitor.sv
// ============================================================================
// Module   : tb_seq_monitor
// Brief    : Directed and random stimulus against a golden-period position model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] number = 3'd0;
  logic       err_clr = 1'b0;

  logic       locked, err_pulse, err_sticky;
  logic [7:0] err_cnt, period_cnt;
  logic       locked2, err_pulse2, err_sticky2;
  logic [1:0] err_cnt2;
  logic [7:0] period_cnt2;

  int checks = 0;
  int errors = 0;

  // One golden period for HOLD_LEN = 3, indexed by position in the period.
  logic [2:0] gold [7] = '{3'd0, 3'd5, 3'd1, 3'd3, 3'd3, 3'd3, 3'd6};

  bit m_locked, m_pulse, m_sticky;
  int m_pos, m_errs, m_per;

  always #5 clk = ~clk;

  seq_monitor #(.HOLD_LEN(3), .ERR_CNT_W(8), .PER_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .number(number), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .period_cnt(period_cnt)
  );

  seq_monitor #(.HOLD_LEN(3), .ERR_CNT_W(2), .PER_CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .number(number), .err_clr(err_clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
    .err_cnt(err_cnt2), .period_cnt(period_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int e8, e2, p8;
    e8 = (m_errs > 255) ? 255 : m_errs;
    e2 = (m_errs > 3) ? 3 : m_errs;
    p8 = (m_per > 255) ? 255 : m_per;
    check({ph, "_locked"},  {31'd0, locked},     {31'd0, m_locked});
    check({ph, "_pulse"},   {31'd0, err_pulse},  {31'd0, m_pulse});
    check({ph, "_sticky"},  {31'd0, err_sticky}, {31'd0, m_sticky});
    check({ph, "_errcnt"},  {24'd0, err_cnt},    e8);
    check({ph, "_period"},  {24'd0, period_cnt}, p8);
    check({ph, "_locked2"}, {31'd0, locked2},    {31'd0, m_locked});
    check({ph, "_pulse2"},  {31'd0, err_pulse2}, {31'd0, m_pulse});
    check({ph, "_sticky2"}, {31'd0, err_sticky2},{31'd0, m_sticky});
    check({ph, "_errcnt2"}, {30'd0, err_cnt2},   e2);
    check({ph, "_period2"}, {24'd0, period_cnt2},p8);
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    en = 1'($urandom_range(0, 1));
    err_clr = 1'($urandom_range(0, 1));
    number = 3'($urandom_range(0, 7));
    @(posedge clk);
    m_locked = 0; m_pulse = 0; m_sticky = 0;
    m_pos = 0; m_errs = 0; m_per = 0;
    #1;
    check_all(ph);
    rst = 1'b0;
  endtask

  task automatic step(input string ph, input logic e, input logic [2:0] n, input logic c);
    int nx;
    rst = 1'b0; en = e; number = n; err_clr = c;
    @(posedge clk);
    m_pulse = 0;
    if (e) begin
      if (!m_locked) begin
        if (n == 3'd0) begin
          m_locked = 1;
          m_pos = 0;
        end
      end else begin
        nx = (m_pos + 1) % 7;
        if (n == gold[nx]) begin
          m_pos = nx;
          if (nx == 0) m_per++;
        end else begin
          m_locked = 0;
          m_errs++;
          m_pulse = 1;
          m_sticky = 1;
        end
      end
      if (c && !m_pulse) m_sticky = 0;
    end
    #1;
    check_all(ph);
  endtask

  task automatic golden(input string ph, input int first, input int count);
    for (int i = 0; i < count; i++) step(ph, 1'b1, gold[(first + i) % 7], 1'b0);
  endtask

  initial begin
    logic [2:0] junk;
    logic       e, c;
    logic [2:0] n;

    @(posedge clk); #1;
    do_reset("t1_rst");

    // Three golden periods from acquisition.
    golden("t1", 0, 21);
    check("t1_period_is_2", {24'd0, period_cnt}, 32'd2);

    // 111 in the 101 slot, junk without 000, then relock.
    step("t2", 1'b1, 3'd0, 1'b0);
    step("t2_err", 1'b1, 3'b111, 1'b0);
    check("t2_errcnt_is_1", {24'd0, err_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      junk = 3'($urandom_range(1, 7));
      step("t2_hunt", 1'b1, junk, 1'b0);
    end
    step("t2_relock", 1'b1, 3'd0, 1'b0);
    check("t2_relocked", {31'd0, locked}, 32'd1);

    // Short hold, then over-long hold.
    golden("t3a", 1, 4);
    step("t3a_err", 1'b1, 3'b110, 1'b0);
    golden("t3b", 0, 6);
    step("t3b_err", 1'b1, 3'b011, 1'b0);
    check("t3_errcnt_is_3", {24'd0, err_cnt}, 32'd3);

    // Mismatching 000 does not resync; five errors saturate the narrow counter.
    for (int i = 0; i < 5; i++) begin
      step("t4_lock", 1'b1, 3'd0, 1'b0);
      step("t4_err", 1'b1, (i == 0) ? 3'd0 : 3'b100, 1'b0);
    end
    check("t4_errcnt2_sat", {30'd0, err_cnt2}, 32'd3);
    step("t4_lock", 1'b1, 3'd0, 1'b0);
    step("t4_clr_err", 1'b1, 3'b010, 1'b1);
    check("t4_sticky_kept", {31'd0, err_sticky}, 32'd1);
    step("t4_clr", 1'b1, 3'd5, 1'b1);

    // Pause mid-period with random codes, resume where it stopped.
    golden("t5", 0, 3);
    for (int i = 0; i < 4; i++) step("t5_pause", 1'b0, 3'($urandom_range(0, 7)), 1'b0);
    golden("t5_resume", 3, 5);

    // Reset while locked with errors.
    step("t6_lock", 1'b1, 3'd0, 1'b0);
    step("t6_err", 1'b1, 3'd7, 1'b0);
    golden("t6", 0, 3);
    do_reset("t6_rst");
    step("t6_relock", 1'b1, 3'd0, 1'b0);

    // Random: mostly golden traffic with injected faults, pauses, clears, resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_rst");
      end else begin
        e = ($urandom_range(0, 9) != 0);
        c = ($urandom_range(0, 15) == 0);
        if (m_locked && $urandom_range(0, 9) != 0) n = gold[(m_pos + 1) % 7];
        else if (!m_locked && $urandom_range(0, 9) < 4) n = 3'd0;
        else n = 3'($urandom_range(0, 7));
        step("rnd", e, n, c);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
